// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: FSM state encoding and
// default field widths used by pipe_stage_reg and pipe_entry.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int DEF_CTRL_W = 16;
  localparam int DEF_DATA_W = 128;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the pipeline stage: valid bit, control field and data
// field. Clear wins over load; a cleared slot also zeroes its control field
// so a killed beat cannot leak control bits, while data is left in place.
module pipe_entry #(
  parameter int CTRL_W = pipe_pkg::DEF_CTRL_W,
  parameter int DATA_W = pipe_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next slot contents: clear kills the beat, load captures a new one with
  // the control field optionally forced to zero for a bubble.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = bubble ? '0 : in_ctrl;
      data_d  = in_data;
    end
  end

  // Slot registers, wiped by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake. SKID=1 builds a
// two-entry skid buffer with a registered in_ready (no ready path from
// downstream to upstream); SKID=0 is a single register whose in_ready is
// combinational. Also supports bubble insertion, flush and a saturating
// backpressure counter.
module pipe_stage_reg #(
  parameter int CTRL_W = pipe_pkg::DEF_CTRL_W,
  parameter int DATA_W = pipe_pkg::DEF_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic accept, drain;
  logic main_load, main_clear, main_from_skid, main_bubble;
  logic skid_load, skid_clear;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_src_data;

  assign in_ready  = (SKID != 0) ? in_ready_q : (!rst && (!main_valid || out_ready));
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign stall_cnt = stall_q;

  // Occupancy control: decide which slot loads or clears and the next state.
  // Flush overrides everything, so a simultaneous accept is simply dropped.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !drain) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (drain && !accept) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
          end else if (accept && drain) begin
            main_load = 1'b1;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d        = ST_ONE;
            main_load      = skid_valid;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end else begin
      if (accept) begin
        state_d   = ST_ONE;
        main_load = 1'b1;
      end else if (drain) begin
        state_d    = ST_EMPTY;
        main_clear = 1'b1;
      end
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // The skid beat already had its bubble applied when it was accepted.
  assign main_bubble   = bubble && !main_from_skid;
  assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_src_data = main_from_skid ? skid_data : in_data;

  // Backpressure counter: one count per held-but-not-taken cycle, sticking at max.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  // State, registered ready and stall counter; reset drops ready to 0 so
  // upstream sees the stage available only after the first clean edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .bubble  (main_bubble),
    .clear   (main_clear),
    .in_ctrl (main_src_ctrl),
    .in_data (main_src_data),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .bubble  (bubble),
      .clear   (skid_clear),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 2-entry skid instance (CNT_W=3) and a single
// register instance (SKID=0) driven by shared directed stimulus, each checked
// every cycle against a queue model, plus hand-computed literal checks.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         bubble = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready_a = 1'b0;
  logic         out_ready_b = 1'b0;
  logic [15:0]  in_ctrl = '0;
  logic [127:0] in_data = '0;

  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [15:0]  out_ctrl_a, out_ctrl_b;
  logic [127:0] out_data_a, out_data_b;
  logic [2:0]   stall_cnt_a;
  logic [15:0]  stall_cnt_b;

  int vec_cnt = 0;
  int miss_cnt = 0;
  bit run_cmp = 1'b1;

  logic [143:0] qa[$];
  logic [143:0] qb[$];
  int cnta = 0;
  int cntb = 0;
  bit seena = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_ctrl(out_ctrl_a),
    .out_data(out_data_a), .stall_cnt(stall_cnt_a)
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ctrl(out_ctrl_b),
    .out_data(out_data_b), .stall_cnt(stall_cnt_b)
  );

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [15:0] c, input logic [127:0] d,
                               input logic bub, input logic fl, input logic ora, input logic orb);
    in_valid    = iv;
    in_ctrl     = c;
    in_data     = d;
    bubble      = bub;
    flush       = fl;
    out_ready_a = ora;
    out_ready_b = orb;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; bubble = 1'b0;
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue model of the skid instance: up to two beats, ready known one edge late.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      cnta = 0;
      seena = 1'b0;
    end else begin
      bit acc, drn;
      drn = (qa.size() != 0) && out_ready_a;
      acc = in_valid && seena && (qa.size() < 2);
      if ((qa.size() != 0) && !out_ready_a && (cnta < 7)) cnta++;
      if (flush) qa.delete();
      else begin
        if (drn) void'(qa.pop_front());
        if (acc) qa.push_back({(bubble ? 16'h0 : in_ctrl), in_data});
      end
      seena = 1'b1;
    end
  end

  // Queue model of the single-register instance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete();
      cntb = 0;
    end else begin
      bit acc, drn;
      drn = (qb.size() != 0) && out_ready_b;
      acc = in_valid && ((qb.size() == 0) || out_ready_b);
      if ((qb.size() != 0) && !out_ready_b && (cntb < 65535)) cntb++;
      if (flush) qb.delete();
      else begin
        if (drn) void'(qb.pop_front());
        if (acc) qb.push_back({(bubble ? 16'h0 : in_ctrl), in_data});
      end
    end
  end

  // Per-cycle compare of both instances against their models.
  always @(negedge clk) begin
    if (run_cmp) begin
      checkOutput("a_out_valid", out_valid_a, qa.size() != 0);
      if (qa.size() != 0) begin
        checkOutput("a_out_ctrl", out_ctrl_a, qa[0][143:128]);
        checkOutput("a_out_data", out_data_a, qa[0][127:0]);
      end
      checkOutput("a_in_ready", in_ready_a, seena && (qa.size() < 2));
      checkOutput("a_stall_cnt", stall_cnt_a, cnta);
      checkOutput("b_out_valid", out_valid_b, qb.size() != 0);
      if (qb.size() != 0) begin
        checkOutput("b_out_ctrl", out_ctrl_b, qb[0][143:128]);
        checkOutput("b_out_data", out_data_b, qb[0][127:0]);
      end
      checkOutput("b_in_ready", in_ready_b, !rst && ((qb.size() == 0) || out_ready_b));
      checkOutput("b_stall_cnt", stall_cnt_b, cntb);
    end
  end

  initial begin
    #200000;
    miss_cnt++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid_a, 0);
    checkOutput("rst_in_ready", in_ready_a, 0);
    checkOutput("rst_out_data", out_data_a, 0);
    checkOutput("rst_out_ctrl", out_ctrl_a, 0);
    checkOutput("rst_in_ready_b", in_ready_b, 0);
    doReset();
    checkOutput("ready_after_rst", in_ready_a, 1);

    // Stream of 8 beats with free downstream
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h00A5, 128'(i), 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("stream_data", out_data_a, 128'(i));
      checkOutput("stream_valid", out_valid_a, 1);
    end
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stream_end_valid", out_valid_a, 0);
    checkOutput("stream_stall", stall_cnt_a, 0);

    // Backpressure
    doReset();
    applyStimulus(1'b1, 16'h0010, 128'd16, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0011, 128'd17, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_in_ready", in_ready_a, 0);
    checkOutput("bp_hold_data", out_data_a, 128'd16);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0012, 128'd18, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_stall", stall_cnt_a, 5);
    checkOutput("bp_held", out_data_a, 128'd16);
    applyStimulus(1'b1, 16'h0012, 128'd18, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_rel0", out_data_a, 128'd17);
    applyStimulus(1'b1, 16'h0012, 128'd18, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_rel1", out_data_a, 128'd18);
    applyStimulus(1'b1, 16'h0013, 128'd19, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_rel2", out_data_a, 128'd19);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Bubble
    doReset();
    applyStimulus(1'b1, 16'hFFFF, 128'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bub_valid", out_valid_a, 1);
    checkOutput("bub_ctrl", out_ctrl_a, 0);
    checkOutput("bub_data", out_data_a, 128'hDEAD);
    applyStimulus(1'b1, 16'h1234, 128'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bub_skid_ctrl", out_ctrl_a, 16'h1234);
    checkOutput("bub_skid_data", out_data_a, 128'hBEEF);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Flush in TWO, flush with accept and with drain
    doReset();
    applyStimulus(1'b1, 16'h0001, 128'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0002, 128'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 128'h32, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_valid", out_valid_a, 0);
    checkOutput("fl_in_ready", in_ready_a, 1);
    checkOutput("fl_ctrl", out_ctrl_a, 0);
    checkOutput("fl_stall", stall_cnt_a, 2);
    applyStimulus(1'b1, 16'h0004, 128'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("fl_next_data", out_data_a, 128'h33);
    applyStimulus(1'b1, 16'h0005, 128'h34, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("fl_drain_valid", out_valid_a, 0);
    applyStimulus(1'b1, 16'h0006, 128'h35, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("fl_after_data", out_data_a, 128'h35);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Saturation and async reset mid-cycle
    doReset();
    applyStimulus(1'b1, 16'h0040, 128'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_a", stall_cnt_a, 7);
    checkOutput("sat_b", stall_cnt_b, 10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", out_valid_a, 0);
    checkOutput("arst_stall", stall_cnt_a, 0);
    checkOutput("arst_data", out_data_a, 0);
    checkOutput("arst_valid_b", out_valid_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_ready", in_ready_a, 1);

    // Single register: combinational ready and toggling downstream
    applyStimulus(1'b1, 16'h0050, 128'h50, 1'b0, 1'b0, 1'b1, 1'b1);
    out_ready_b = 1'b0;
    #1;
    checkOutput("s0_ready_low", in_ready_b, 0);
    out_ready_b = 1'b1;
    #1;
    checkOutput("s0_ready_high", in_ready_b, 1);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 16'(16'h60 + i), 128'(8'h60 + i), 1'b0, 1'b0, 1'b1, 1'(i % 2));
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("s0_drained", out_valid_b, 0);

    @(negedge clk);
    #1;
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 16: width of the control field that is zeroed on a bubble or flush.
REQ-002 SHALL have parameter DATA_W, default 128: width of the data field, carried unmodified.
REQ-003 SHALL have parameter SKID, default 1: 1 gives a 2-entry skid buffer, 0 gives a single register.
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous kill of all held entries.
REQ-008 SHALL have port bubble, input, 1 bit: the beat accepted this cycle has its ctrl forced to 0.
REQ-009 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-010 SHALL have port in_ready, output, 1 bit: stage can accept a beat.
REQ-011 SHALL have port in_ctrl, input, CTRL_W bits: upstream control field.
REQ-012 SHALL have port in_data, input, DATA_W bits: upstream data field.
REQ-013 SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-015 SHALL have port out_ctrl, output, CTRL_W bits: held control field.
REQ-016 SHALL have port out_data, output, DATA_W bits: held data field.
REQ-017 SHALL have port stall_cnt, output, CNT_W bits: saturating count of backpressured cycles.

Function
REQ-018 A transfer SHALL occur on an edge where valid and ready are both 1; out_valid, out_ctrl and out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 With SKID=1 the stage SHALL hold states EMPTY, ONE (main entry valid) and TWO (main and skid entries valid).
REQ-020 EMPTY SHALL go to ONE on an accept.
REQ-021 ONE SHALL go to TWO on accept with no drain, go to EMPTY on drain with no accept, and otherwise stay in ONE.
REQ-022 TWO SHALL go to ONE on drain, with the skid entry moving to the main entry.
REQ-023 With SKID=1, in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in TWO; there SHALL be no combinational in_ready-from-out_ready path.
REQ-024 With SKID=1 and out_ready held at 1, the stage SHALL sustain one beat per cycle with 1-cycle latency.
REQ-025 With SKID=0 the stage SHALL use a single entry, and in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-026 out_valid SHALL equal main-entry valid, and out_ctrl/out_data SHALL come from the main entry.
REQ-027 Beats SHALL leave in acceptance order; there SHALL be no loss or duplication.
REQ-028 bubble=1 on an accept SHALL store ctrl as all-zero and in_data unchanged; bubble SHALL have no effect when no accept occurs.
REQ-029 flush=1 SHALL set the state to EMPTY next cycle, clear both valids, and zero the stored ctrl; data registers MAY retain their values.
REQ-030 flush SHALL take priority over a simultaneous accept, which is discarded; a simultaneous drain SHALL still count as transferred downstream.
REQ-031 stall_cnt SHALL increment on each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and never wrap.
REQ-032 stall_cnt SHALL be unaffected by flush.

Reset
REQ-033 rst=1 SHALL immediately set the state to EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid entry cleared, stall_cnt=0.
REQ-034 in_ready SHALL be 0 while rst=1 and SHALL be 1 on the first clock edge after rst deasserts.
REQ-035 rst asserted mid-transfer SHALL drop all held beats, with no partial output.

Structure
REQ-036 The state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) SHALL live in shared package pipe_pkg, with pipe_pkg also holding the default CTRL_W/DATA_W constants.
REQ-037 One sub-module SHALL be used, pipe_entry: a valid+ctrl+data register with load, bubble-zero and clear inputs, instantiated once (SKID=0) or twice (SKID=1).
REQ-038 There SHALL be no other sub-modules and no memories; implementation SHALL be flops only.

Verification
REQ-039 Reset then stream: rst pulse, then 8 beats data=0..7, ctrl=16'h00A5, out_ready=1 -> out data 0..7 on consecutive cycles, 1-cycle latency, stall_cnt=0.
REQ-040 Backpressure: out_ready=0 for 5 cycles during a stream -> accepts 2 beats, in_ready=0 after the 2nd, out_data held, stall_cnt=5; after release, order is preserved with no loss.
REQ-041 Bubble: beat ctrl=16'hFFFF, data=32'hDEAD with bubble=1 -> out_ctrl=0, out_data=32'hDEAD, out_valid=1.
REQ-042 Flush in TWO with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, the incoming beat is never emitted, and the following beat appears normally.
REQ-043 Saturation: CNT_W=3, out_ready=0 for 10 cycles -> stall_cnt stops at 7; an async rst mid-cycle clears it and out_valid immediately.
REQ-044 SKID=0: out_ready toggling 1/0 each cycle -> in_ready follows !out_valid || out_ready combinationally, and the beat order is intact.
